// File: rtl/registered_mux_n.sv
// Registered N-input multiplexer with a one-entry valid/ready output stage.
// An accepted transfer loads the selected input slice into the output register;
// an accepted out-of-range select keeps the old data but still produces a beat,
// and is recorded by a sticky flag and a saturating error counter.
module registered_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        control,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [7:0]              err_count,
    input  logic                    err_clear
);

    // Every code the select can take gets a slot; codes at or above NUM_IN map
    // to zero so the mux index can never run past the array.
    localparam int NUM_SLOTS = 1 << SEL_W;

    // Width-matched copy of NUM_IN, one bit wider than the select so that
    // NUM_IN = 2^SEL_W is representable.
    localparam logic [SEL_W:0] NUM_IN_L = NUM_IN[SEL_W:0];

    logic [WIDTH-1:0] slice_arr [NUM_SLOTS];

    logic [WIDTH-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [7:0]       err_count_q, err_count_d;

    logic accept;
    logic in_range;

    // Unpack the input bus into per-input slices, padding unused codes with zero.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slice
            if (gi < NUM_IN) begin : g_used
                assign slice_arr[gi] = in_bus[gi*WIDTH +: WIDTH];
            end else begin : g_unused
                assign slice_arr[gi] = '0;
            end
        end
    endgenerate

    // The output stage can take a new beat when empty or when it drains this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_range = ({1'b0, control} < NUM_IN_L);

    // Next-state for the data/valid stage: load on accept, drop valid on drain.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            if (in_range) begin
                out_d = slice_arr[control];
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Next-state for the error bookkeeping; a clear overrides a same-cycle error.
    always_comb begin
        sel_err_d   = sel_err_q;
        err_count_d = err_count_q;
        if (err_clear) begin
            sel_err_d   = 1'b0;
            err_count_d = 8'd0;
        end else if (accept && !in_range) begin
            sel_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // Data and valid registers; reset discards any pending beat immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Error flag and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_registered_mux_n.sv
// Directed bench for registered_mux_n: a vector table on the default build,
// hand-written sequences for saturation and asynchronous reset, and a select
// sweep on an 8-input, 16-bit build.
module tb_registered_mux_n;

    logic clk = 1'b0;
    logic reset;

    // Default build: WIDTH 32, NUM_IN 5, SEL_W 3
    logic [5*32-1:0] in_bus_a;
    logic [2:0]      control_a;
    logic            in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [31:0]     out_a;
    logic            sel_err_a, err_clear_a;
    logic [7:0]      err_count_a;

    // Full-code build: WIDTH 16, NUM_IN 8, SEL_W 3
    logic [8*16-1:0] in_bus_b;
    logic [2:0]      control_b;
    logic            in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [15:0]     out_b;
    logic            sel_err_b, err_clear_b;
    logic [7:0]      err_count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    registered_mux_n dut_a (
        .clk(clk), .reset(reset), .in_bus(in_bus_a), .control(control_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .out(out_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .sel_err(sel_err_a),
        .err_count(err_count_a), .err_clear(err_clear_a)
    );

    registered_mux_n #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) dut_b (
        .clk(clk), .reset(reset), .in_bus(in_bus_b), .control(control_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .out(out_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .sel_err(sel_err_b),
        .err_count(err_count_b), .err_clear(err_clear_b)
    );

    typedef struct {
        logic [2:0]  ctl;
        logic        iv;
        logic        ordy;
        logic        clr;
        logic        exp_rdy;   // in_ready just before the edge
        logic [31:0] exp_out;   // outputs just after the edge
        logic        exp_ov;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle on the default build: drive at negedge, check ready, check outputs after edge.
    task automatic apply_a(input vec_t v, input int idx);
        @(negedge clk);
        control_a   = v.ctl;
        in_valid_a  = v.iv;
        out_ready_a = v.ordy;
        err_clear_a = v.clr;
        #1;
        check($sformatf("v%0d in_ready", idx), {31'd0, in_ready_a}, {31'd0, v.exp_rdy});
        @(posedge clk);
        #1;
        check($sformatf("v%0d out", idx), out_a, v.exp_out);
        check($sformatf("v%0d out_valid", idx), {31'd0, out_valid_a}, {31'd0, v.exp_ov});
        check($sformatf("v%0d sel_err", idx), {31'd0, sel_err_a}, {31'd0, v.exp_err});
        check($sformatf("v%0d err_count", idx), {24'd0, err_count_a}, {24'd0, v.exp_cnt});
        $display("vec %0d ctl=%0d iv=%0b ordy=%0b clr=%0b -> out=%h ov=%0b err=%0b cnt=%0d",
                 idx, v.ctl, v.iv, v.ordy, v.clr, out_a, out_valid_a, sel_err_a, err_count_a);
    endtask

    initial begin
        // Input slices: 0..4
        in_bus_a = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h12345678};
        for (int k = 0; k < 8; k++) in_bus_b[k*16 +: 16] = 16'hB000 + 16'(k) * 16'h0111;

        //           ctl  iv  ordy clr  rdy  out            ov  err cnt
        vecs[0]  = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 8'd0};
        vecs[5]  = '{3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1, 1'b0, 8'd0};
        // Backpressure: three stalled cycles with in_valid high
        vecs[6]  = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44444444, 1'b1, 1'b0, 8'd0};
        vecs[7]  = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44444444, 1'b1, 1'b0, 8'd0};
        vecs[8]  = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44444444, 1'b1, 1'b0, 8'd0};
        // Release: accepted in the same cycle
        vecs[9]  = '{3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 8'd0};
        // Drain without a new beat, then idle inputs are ignored
        vecs[10] = '{3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 8'd0};
        // Load 12345678, then out-of-range selects keep the data
        vecs[12] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 8'd0};
        vecs[13] = '{3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 8'd1};
        vecs[14] = '{3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 8'd2};
        // Clear beats a same-cycle out-of-range accept
        vecs[15] = '{3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 8'd0};
        // Stalled out-of-range select is not accepted and not counted
        vecs[16] = '{3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0, 8'd0};
        vecs[17] = '{3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1, 1'b0, 8'd0};

        control_a = 3'd0; in_valid_a = 1'b0; out_ready_a = 1'b1; err_clear_a = 1'b0;
        control_b = 3'd0; in_valid_b = 1'b0; out_ready_b = 1'b1; err_clear_b = 1'b0;

        // Reset state
        reset = 1'b1;
        #1;
        check("rst out", out_a, 32'd0);
        check("rst out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst in_ready", {31'd0, in_ready_a}, 32'd1);
        check("rst err_count", {24'd0, err_count_a}, 32'd0);
        $display("reset: out=%h ov=%0b rdy=%0b cnt=%0d", out_a, out_valid_a, in_ready_a, err_count_a);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) apply_a(vecs[i], i);

        // Saturation: 300 out-of-range accepts
        @(negedge clk);
        control_a = 3'd6; in_valid_a = 1'b1; out_ready_a = 1'b1; err_clear_a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (i == 254 || i == 299) begin
                check($sformatf("sat cnt after %0d", i + 1), {24'd0, err_count_a}, 32'd255);
                check($sformatf("sat err after %0d", i + 1), {31'd0, sel_err_a}, 32'd1);
                check($sformatf("sat out after %0d", i + 1), out_a, 32'h44444444);
                $display("sat %0d: cnt=%0d err=%0b out=%h", i + 1, err_count_a, sel_err_a, out_a);
            end
            if (i == 253) begin
                check("sat cnt after 254", {24'd0, err_count_a}, 32'd254);
                $display("sat 254: cnt=%0d", err_count_a);
            end
        end
        @(negedge clk);
        in_valid_a = 1'b0; err_clear_a = 1'b1;
        @(posedge clk);
        #1;
        check("clear err", {31'd0, sel_err_a}, 32'd0);
        check("clear cnt", {24'd0, err_count_a}, 32'd0);
        $display("clear: err=%0b cnt=%0d", sel_err_a, err_count_a);

        // Asynchronous reset between edges with a pending beat
        @(negedge clk);
        err_clear_a = 1'b0; control_a = 3'd2; in_valid_a = 1'b1; out_ready_a = 1'b0;
        @(posedge clk);
        #1;
        check("pre-rst out", out_a, 32'hDEADBEEF);
        check("pre-rst in_ready", {31'd0, in_ready_a}, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async rst out", out_a, 32'd0);
        check("async rst out_valid", {31'd0, out_valid_a}, 32'd0);
        check("async rst in_ready", {31'd0, in_ready_a}, 32'd1);
        $display("async reset: out=%h ov=%0b rdy=%0b", out_a, out_valid_a, in_ready_a);
        control_a = 3'd3; in_valid_a = 1'b1; out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        check("held rst out_valid", {31'd0, out_valid_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first accept out", out_a, 32'h33333333);
        check("first accept out_valid", {31'd0, out_valid_a}, 32'd1);
        $display("post reset: out=%h ov=%0b", out_a, out_valid_a);

        // Full-code build: every select is routed, no error possible
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            control_b = 3'(k); in_valid_b = 1'b1; out_ready_b = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("b sel%0d out", k), {16'd0, out_b}, {16'd0, 16'hB000 + 16'(k) * 16'h0111});
            check($sformatf("b sel%0d err", k), {31'd0, sel_err_b}, 32'd0);
            $display("b sel=%0d out=%h ov=%0b err=%0b cnt=%0d", k, out_b, out_valid_b, sel_err_b, err_count_b);
        end
        check("b err_count", {24'd0, err_count_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
